// File: rtl/addsub_unpack_if.sv
// Valid/ready bus for the add/sub unpack stage: the S/D pair in, recovered A/B
// and the error count out.
interface addsub_unpack_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH:0]     in_sum;
  logic [WIDTH:0]     in_diff;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_a;
  logic [WIDTH-1:0]   out_b;
  logic               out_err;
  logic [COUNT_W-1:0] err_count;

  // master is the producer/consumer around the block, slave is the block
  modport master (
    output in_valid, in_sum, in_diff, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_err, err_count
  );

  modport slave (
    input  in_valid, in_sum, in_diff, out_ready,
    output in_ready, out_valid, out_a, out_b, out_err, err_count
  );
endinterface

// File: rtl/addsub_unpack.sv
// Recovers A and B from S = A+B and D = A-B through a two-stage valid/ready
// pipeline; flags inconsistent pairs and keeps a saturating error count.
module addsub_unpack #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  addsub_unpack_if.slave bus
);
  localparam int unsigned PW = WIDTH + 3;

  logic                 s1_valid;
  logic signed [PW-1:0] s1_p;
  logic signed [PW-1:0] s1_m;
  logic                 s1_par;

  logic                 out_valid;
  logic [WIDTH-1:0]     out_a;
  logic [WIDTH-1:0]     out_b;
  logic                 out_err;
  logic [COUNT_W-1:0]   err_count;

  logic                 adv1;
  logic                 adv2;
  logic signed [PW-1:0] sum_x;
  logic signed [PW-1:0] diff_x;
  logic signed [PW-1:0] a_full;
  logic signed [PW-1:0] b_full;
  logic                 err_c;
  logic                 deliver;

  // Stage 2 frees up when empty or drained; stage 1 when empty or stage 2 moves.
  always_comb begin
    adv2    = !out_valid || out_ready_w();
    adv1    = !s1_valid || adv2;
    deliver = out_valid && bus.out_ready;
  end

  function automatic logic out_ready_w();
    return bus.out_ready;
  endfunction

  // Widen S as unsigned and D as signed so P and M cannot overflow.
  always_comb begin
    sum_x  = $signed({2'b00, bus.in_sum});
    diff_x = $signed({{2{bus.in_diff[WIDTH]}}, bus.in_diff});
  end

  // A value is representable iff every bit above WIDTH-1 is zero (covers < 0 too).
  always_comb begin
    a_full = s1_p >>> 1;
    b_full = s1_m >>> 1;
    err_c  = s1_par || (|a_full[PW-1:WIDTH]) || (|b_full[PW-1:WIDTH]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_m     <= '0;
      s1_par   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_p   <= sum_x + diff_x;
        s1_m   <= sum_x - diff_x;
        s1_par <= bus.in_sum[0] ^ bus.in_diff[0];
      end
    end
  end

  // Result registers only change when a new pair lands, so they hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_err   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_err <= err_c;
        out_a   <= err_c ? '0 : a_full[WIDTH-1:0];
        out_b   <= err_c ? '0 : b_full[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (deliver && out_err && (err_count != {COUNT_W{1'b1}})) begin
      err_count <= err_count + COUNT_W'(1);
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = out_valid;
  assign bus.out_a     = out_a;
  assign bus.out_b     = out_b;
  assign bus.out_err   = out_err;
  assign bus.err_count = err_count;
endmodule

// File: tb/tb_addsub_unpack.sv
// Bench for addsub_unpack: directed corner cases plus random traffic scored
// against an integer model of A=(S+D)/2, B=(S-D)/2.
module tb_addsub_unpack;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;

  typedef struct {
    int a;
    int b;
    bit e;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cnt_exp;
  exp_t sb[$];

  bit          prev_hold;
  logic [W-1:0] prev_a;
  logic [W-1:0] prev_b;
  logic         prev_e;

  addsub_unpack_if #(.WIDTH(W), .COUNT_W(CW)) mif ();
  addsub_unpack_if #(.WIDTH(W), .COUNT_W(2))  sif ();

  addsub_unpack #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  addsub_unpack #(.WIDTH(W), .COUNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: recover operands with plain integer arithmetic.
  function automatic exp_t model(input int s, input int d);
    exp_t r;
    r.e = ((s + d) % 2) != 0;
    r.a = (s + d) / 2;
    r.b = (s - d) / 2;
    if (r.e || r.a < 0 || r.a > 255 || r.b < 0 || r.b > 255) begin
      r.e = 1'b1;
      r.a = 0;
      r.b = 0;
    end
    return r;
  endfunction

  // Scoreboard/monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      cnt_exp   = 0;
      prev_hold = 1'b0;
    end else begin
      check_eq("err_count", 32'(mif.err_count), 32'(cnt_exp));
      if (prev_hold) begin
        check_eq("hold_valid", 32'(mif.out_valid), 32'd1);
        check_eq("hold_a", 32'(mif.out_a), 32'(prev_a));
        check_eq("hold_b", 32'(mif.out_b), 32'(prev_b));
        check_eq("hold_err", 32'(mif.out_err), 32'(prev_e));
      end
      if (mif.in_valid && mif.in_ready)
        sb.push_back(model(int'(mif.in_sum), int'($signed(mif.in_diff))));
      if (mif.out_valid && mif.out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("sb_a", 32'(mif.out_a), 32'(e.a));
          check_eq("sb_b", 32'(mif.out_b), 32'(e.b));
          check_eq("sb_err", 32'(mif.out_err), 32'(e.e));
          if (e.e && cnt_exp < 65535) cnt_exp++;
        end
      end
      prev_hold = mif.out_valid && !mif.out_ready;
      prev_a    = mif.out_a;
      prev_b    = mif.out_b;
      prev_e    = mif.out_err;
    end
  end

  // Present one pair and hold it until accepted; starts and ends just after a rising edge.
  task automatic offer(input int s, input int d);
    int n;
    mif.in_valid = 1'b1;
    mif.in_sum   = 9'(s);
    mif.in_diff  = 9'(d);
    n = 0;
    @(negedge clk);
    while (!mif.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    mif.in_valid = 1'b0;
  endtask

  // After an accept into an empty pipe with out_ready=1: result appears on the second edge.
  task automatic lat_check(input string tag, input int a, input int b, input bit e);
    @(negedge clk);
    check_eq({tag, "_lat1"}, 32'(mif.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_lat2"}, 32'(mif.out_valid), 32'd1);
    check_eq({tag, "_a"}, 32'(mif.out_a), 32'(a));
    check_eq({tag, "_b"}, 32'(mif.out_b), 32'(b));
    check_eq({tag, "_err"}, 32'(mif.out_err), 32'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    int s, d, a, b;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    mif.in_valid = 1'b0; mif.in_sum = '0; mif.in_diff = '0; mif.out_ready = 1'b1;
    sif.in_valid = 1'b0; sif.in_sum = 9'd3; sif.in_diff = '0; sif.out_ready = 1'b1;
    #22;
    check_eq("rst_valid", 32'(mif.out_valid), 32'd0);
    check_eq("rst_cnt", 32'(mif.err_count), 32'd0);
    check_eq("rst_a", 32'(mif.out_a), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Nominal and edge pairs
    offer(300, 10);   lat_check("nom", 155, 145, 1'b0);
    offer(255, -255); lat_check("edge0", 0, 255, 1'b0);
    offer(510, 0);    lat_check("edge1", 255, 255, 1'b0);

    // Parity and range errors
    offer(3, 0);      lat_check("par", 0, 0, 1'b1);
    @(negedge clk); check_eq("cnt1", 32'(mif.err_count), 32'd1);
    @(posedge clk); #1;
    offer(510, 2);    lat_check("rng", 0, 0, 1'b1);
    @(negedge clk); check_eq("cnt2", 32'(mif.err_count), 32'd2);
    @(posedge clk); #1;

    // Backpressure: two pairs fill the pipe, the third is refused
    mif.out_ready = 1'b0;
    offer(300, 10);
    offer(100, -20);
    mif.in_valid = 1'b1; mif.in_sum = 9'd20; mif.in_diff = 9'd20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_ready", 32'(mif.in_ready), 32'd0);
      check_eq("bp_a", 32'(mif.out_a), 32'd155);
      @(posedge clk); #1;
    end
    mif.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_rel_ready", 32'(mif.in_ready), 32'd1);
    check_eq("bp_ov0", 32'(mif.out_valid), 32'd1);
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    @(negedge clk); check_eq("bp_ov1", 32'(mif.out_valid), 32'd1);
    check_eq("bp_a1", 32'(mif.out_a), 32'd40);
    @(posedge clk); @(negedge clk); check_eq("bp_ov2", 32'(mif.out_valid), 32'd1);
    check_eq("bp_a2", 32'(mif.out_a), 32'd20);
    @(posedge clk); @(negedge clk); check_eq("bp_ov3", 32'(mif.out_valid), 32'd0);
    @(posedge clk); #1;

    // Saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      sif.in_valid = 1'b1;
      @(posedge clk); #1;
      sif.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("sat_%0d", i), 32'(sif.err_count), (i < 3) ? 32'(i + 1) : 32'd3);
      @(posedge clk); #1;
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = mif.in_valid && mif.in_ready;
      @(posedge clk); #1;
      if (!mif.in_valid || acc) begin
        if ($urandom_range(0, 4) == 0) begin
          s = int'($urandom_range(0, 511));
          d = int'($urandom_range(0, 511)) - 256;
        end else begin
          a = int'($urandom_range(0, 255));
          b = int'($urandom_range(0, 255));
          s = a + b;
          d = a - b;
        end
        mif.in_valid = ($urandom_range(0, 3) != 0);
        mif.in_sum   = 9'(s);
        mif.in_diff  = 9'(d);
      end
      mif.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    mif.in_valid  = 1'b0;
    mif.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset with the pipeline full
    offer(3, 0);
    lat_check("pre_rst", 0, 0, 1'b1);
    mif.out_ready = 1'b0;
    offer(300, 10);
    offer(100, -20);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(mif.out_valid), 32'd0);
    check_eq("arst_a", 32'(mif.out_a), 32'd0);
    check_eq("arst_b", 32'(mif.out_b), 32'd0);
    check_eq("arst_err", 32'(mif.out_err), 32'd0);
    check_eq("arst_cnt", 32'(mif.err_count), 32'd0);
    check_eq("arst_ready", 32'(mif.in_ready), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    mif.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_valid", 32'(mif.out_valid), 32'd0);
    offer(300, 10); lat_check("post_rst", 155, 145, 1'b0);
    offer(3, 0);    lat_check("post_par", 0, 0, 1'b1);
    @(negedge clk); check_eq("post_cnt", 32'(mif.err_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
